// File: rtl/xif_mac_pkg.sv
// Shared types and constants for the XIF MAC coprocessor: opcode and funct3
// encodings, FSM states, and the packed XIF transaction structs.
package xif_mac_pkg;

    localparam int XIF_ID_WIDTH  = 4;
    localparam int XIF_NUM_RS    = 2;
    localparam int XIF_RFR_WIDTH = 32;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam int         MAC_CYCLES     = 4;

    typedef enum logic [2:0] {
        OP_MAC    = 3'b000,
        OP_RDACC  = 3'b001,
        OP_CLRACC = 3'b010,
        OP_POPCNT = 3'b011
    } xmac_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_COMMIT,
        ST_EXEC,
        ST_RESULT
    } xmac_state_e;

    typedef struct packed {
        logic [15:0]             instr;
        logic [1:0]              mode;
        logic [XIF_ID_WIDTH-1:0] id;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]                                instr;
        logic [1:0]                                 mode;
        logic [XIF_ID_WIDTH-1:0]                    id;
        logic [XIF_NUM_RS-1:0][XIF_RFR_WIDTH-1:0]   rs;
        logic [XIF_NUM_RS-1:0]                      rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic                    commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [31:0]             addr;
        logic [1:0]              mode;
        logic                    we;
        logic [1:0]              size;
        logic [31:0]             wdata;
        logic                    last;
        logic                    spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [31:0]             rdata;
        logic                    err;
        logic                    dbg;
    } x_mem_result_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [31:0]             data;
        logic [4:0]              rd;
        logic                    we;
        logic                    exc;
        logic [5:0]              exccode;
        logic                    err;
        logic                    dbg;
    } x_result_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/if_xif.sv
// Reduced CORE-V-XIF bundle carrying only what the MAC coprocessor and its
// bridge exchange; modports give the coprocessor-side view of each channel.
interface if_xif;
    import xif_mac_pkg::*;

    logic               compressed_valid;
    logic               compressed_ready;
    x_compressed_req_t  compressed_req;
    x_compressed_resp_t compressed_resp;

    logic               issue_valid;
    logic               issue_ready;
    x_issue_req_t       issue_req;
    x_issue_resp_t      issue_resp;

    logic               commit_valid;
    x_commit_t          commit;

    logic               mem_valid;
    logic               mem_ready;
    x_mem_req_t         mem_req;
    x_mem_resp_t        mem_resp;

    logic               mem_result_valid;
    x_mem_result_t      mem_result;

    logic               result_valid;
    logic               result_ready;
    x_result_t          result;

    modport coproc_compressed (
        input  compressed_valid, compressed_req,
        output compressed_ready, compressed_resp
    );

    modport coproc_issue (
        input  issue_valid, issue_req,
        output issue_ready, issue_resp
    );

    modport coproc_commit (
        input  commit_valid, commit
    );

    modport coproc_mem (
        input  mem_ready, mem_resp,
        output mem_valid, mem_req
    );

    modport coproc_mem_result (
        input  mem_result_valid, mem_result
    );

    modport coproc_result (
        input  result_ready,
        output result_valid, result
    );

endinterface

// File: rtl/xif_mac_mul_iter.sv
// Iterative 32x32 multiplier keeping the low 32 bits. One byte of b is
// folded in per cycle, LSB byte first; done pulses on the final byte with
// the complete product on o_p in that same cycle.
module xif_mac_mul_iter
    import xif_mac_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_p
);

    localparam logic [1:0] LAST_BYTE = 2'(MAC_CYCLES - 1);

    logic        r_busy;
    logic [1:0]  r_cnt;
    logic [31:0] r_sum;
    logic [7:0]  w_byte;
    logic [31:0] w_pp;
    logic [31:0] w_sum;

    // Partial product for the current byte, shifted into place and summed.
    always_comb begin
        w_byte = i_b[{r_cnt, 3'b000} +: 8];
        w_pp   = (i_a * {24'd0, w_byte}) << {r_cnt, 3'b000};
        w_sum  = (r_busy ? r_sum : 32'd0) + w_pp;
    end

    // Byte counter and running sum; the start cycle already consumes byte 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
        end else if (r_busy) begin
            if (r_cnt == LAST_BYTE) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                r_sum  <= '0;
            end else begin
                r_cnt <= r_cnt + 2'd1;
                r_sum <= w_sum;
            end
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= 2'd1;
            r_sum  <= w_sum;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == LAST_BYTE);
    assign o_p    = w_sum;

endmodule

// File: rtl/xif_mac_coproc.sv
// CORE-V-XIF coprocessor with a 32-bit accumulator: MAC, RDACC, CLRACC and
// POPCNT on custom-0. One instruction in flight; the accumulator changes
// only in the last EXEC cycle, so killed instructions never touch it.
//
// state          | meaning
// ST_IDLE        | ready for issue (when both source operands are valid)
// ST_WAIT_COMMIT | accepted, waiting for commit or kill of the latched id
// ST_EXEC        | executing; 1 cycle, or MAC_CYCLES for MAC
// ST_RESULT      | result_valid held with stable payload until result_ready
module xif_mac_coproc
    import xif_mac_pkg::*;
#(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_NUM_RS    = 2,
    parameter int X_RFR_WIDTH = 32
) (
    input logic              clk_i,
    input logic              rst_ni,
    if_xif.coproc_compressed xif_compressed_if,
    if_xif.coproc_issue      xif_issue_if,
    if_xif.coproc_commit     xif_commit_if,
    if_xif.coproc_mem        xif_mem_if,
    if_xif.coproc_mem_result xif_mem_result_if,
    if_xif.coproc_result     xif_result_if
);

    xmac_state_e            r_state;
    xmac_state_e            w_state_nxt;

    logic [31:0]            w_instr;
    logic [2:0]             w_funct3;
    logic [X_NUM_RS-1:0]    w_rs_valid;
    logic                   w_accept;
    logic                   w_writeback;
    logic                   w_issue_ready;
    logic                   w_issue_hs;
    logic                   w_commit_issue_match;
    logic                   w_commit_wait_match;
    logic                   w_commit_kill;

    logic [X_ID_WIDTH-1:0]  r_id;
    logic [4:0]             r_rd;
    xmac_op_e               r_op;
    logic [X_RFR_WIDTH-1:0] r_rs1;
    logic [X_RFR_WIDTH-1:0] r_rs2;
    logic                   r_we;
    logic [31:0]            r_acc;
    logic [31:0]            r_result;

    logic                   w_exec_done;
    logic                   w_mul_start;
    logic                   w_mul_busy;
    logic                   w_mul_done;
    logic [31:0]            w_mul_p;
    logic [31:0]            w_exec_val;
    logic                   w_result_valid;

    assign w_instr    = xif_issue_if.issue_req.instr;
    assign w_funct3   = w_instr[14:12];
    assign w_rs_valid = xif_issue_if.issue_req.rs_valid;

    // funct3 values 000..011 are the only defined operations.
    assign w_accept    = rst_ni && (w_instr[6:0] == OPCODE_CUSTOM0) &&
                         (w_instr[31:25] == 7'd0) && (w_funct3[2] == 1'b0);
    assign w_writeback = w_accept && (w_funct3 != OP_CLRACC);

    assign w_issue_ready = rst_ni && (r_state == ST_IDLE) && (w_rs_valid[1:0] == 2'b11);
    assign w_issue_hs    = xif_issue_if.issue_valid && w_issue_ready;

    assign w_commit_kill        = xif_commit_if.commit.commit_kill;
    assign w_commit_issue_match = xif_commit_if.commit_valid &&
                                  (xif_commit_if.commit.id == xif_issue_if.issue_req.id);
    assign w_commit_wait_match  = xif_commit_if.commit_valid &&
                                  (xif_commit_if.commit.id == r_id);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus multiplier start and execution-complete strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_exec_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue_hs && w_accept) begin
                    if (w_commit_issue_match) begin
                        w_state_nxt = w_commit_kill ? ST_IDLE : ST_EXEC;
                    end else begin
                        w_state_nxt = ST_WAIT_COMMIT;
                    end
                end
            end
            ST_WAIT_COMMIT: begin
                if (w_commit_wait_match) begin
                    w_state_nxt = w_commit_kill ? ST_IDLE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_op == OP_MAC) begin
                    w_mul_start = !w_mul_busy;
                    w_exec_done = w_mul_done;
                end else begin
                    w_exec_done = 1'b1;
                end
                if (w_exec_done) begin
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (xif_result_if.result_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    xif_mac_mul_iter u_mul (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_start (w_mul_start),
        .i_a     (r_rs1),
        .i_b     (r_rs2),
        .o_busy  (w_mul_busy),
        .o_done  (w_mul_done),
        .o_p     (w_mul_p)
    );

    // Value produced by the finishing operation; CLRACC yields zero.
    always_comb begin
        w_exec_val = '0;
        case (r_op)
            OP_MAC:    w_exec_val = r_acc + w_mul_p;
            OP_RDACC:  w_exec_val = r_acc;
            OP_CLRACC: w_exec_val = '0;
            OP_POPCNT: w_exec_val = {26'd0, popcount32(r_rs1)};
            default:   w_exec_val = '0;
        endcase
    end

    // Instruction latches on accept; accumulator and result on EXEC completion.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_id     <= '0;
            r_rd     <= '0;
            r_op     <= OP_MAC;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_we     <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_issue_hs && w_accept) begin
                r_id  <= xif_issue_if.issue_req.id;
                r_rd  <= w_instr[11:7];
                r_op  <= xmac_op_e'(w_funct3);
                r_rs1 <= xif_issue_if.issue_req.rs[0];
                r_rs2 <= xif_issue_if.issue_req.rs[1];
                r_we  <= w_writeback;
            end
            if ((r_state == ST_EXEC) && w_exec_done) begin
                r_result <= w_exec_val;
                if ((r_op == OP_MAC) || (r_op == OP_CLRACC)) begin
                    r_acc <= w_exec_val;
                end
            end
        end
    end

    assign w_result_valid = rst_ni && (r_state == ST_RESULT);

    assign xif_issue_if.issue_ready = w_issue_ready;

    // Issue response is purely a decode of the presented instruction.
    always_comb begin
        xif_issue_if.issue_resp           = '0;
        xif_issue_if.issue_resp.accept    = w_accept;
        xif_issue_if.issue_resp.writeback = w_writeback;
    end

    assign xif_result_if.result_valid = w_result_valid;

    // Result payload is zero whenever no result is being offered.
    always_comb begin
        xif_result_if.result = '0;
        if (w_result_valid) begin
            xif_result_if.result.id   = r_id;
            xif_result_if.result.data = r_result;
            xif_result_if.result.rd   = r_rd;
            xif_result_if.result.we   = r_we;
        end
    end

    assign xif_compressed_if.compressed_ready = 1'b0;
    assign xif_compressed_if.compressed_resp  = '0;
    assign xif_mem_if.mem_valid               = 1'b0;
    assign xif_mem_if.mem_req                 = '0;

endmodule

// File: tb/tb_xif_mac_coproc.sv
// Directed bench for the XIF MAC coprocessor. Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns after that.
module tb_xif_mac_coproc;
    import xif_mac_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    if_xif xif();

    xif_mac_coproc #(
        .X_ID_WIDTH  (4),
        .X_NUM_RS    (2),
        .X_RFR_WIDTH (32)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .xif_compressed_if (xif),
        .xif_issue_if      (xif),
        .xif_commit_if     (xif),
        .xif_mem_if        (xif),
        .xif_mem_result_if (xif),
        .xif_result_if     (xif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, 5'd2, 5'd1, f3, rd, OPCODE_CUSTOM0};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one issue (optionally with commit) for exactly one cycle.
    task automatic do_issue(input logic [31:0] instr, input logic [3:0] id,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic cmt, input logic kill,
                            output logic rdy, output logic acc, output logic wb);
        xif.issue_valid           = 1'b1;
        xif.issue_req.instr       = instr;
        xif.issue_req.id          = id;
        xif.issue_req.rs[0]       = a;
        xif.issue_req.rs[1]       = b;
        xif.commit_valid          = cmt;
        xif.commit.id             = id;
        xif.commit.commit_kill    = kill;
        #1;
        rdy = xif.issue_ready;
        acc = xif.issue_resp.accept;
        wb  = xif.issue_resp.writeback;
        step();
        xif.issue_valid        = 1'b0;
        xif.commit_valid       = 1'b0;
        xif.commit.commit_kill = 1'b0;
    endtask

    task automatic commit_pulse(input logic [3:0] id, input logic kill);
        xif.commit_valid       = 1'b1;
        xif.commit.id          = id;
        xif.commit.commit_kill = kill;
        step();
        xif.commit_valid       = 1'b0;
        xif.commit.commit_kill = 1'b0;
    endtask

    // Called one cycle after the handshake; lat counts cycles from the handshake.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!xif.result_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic take_result(input string tag);
        xif.result_ready = 1'b1;
        step();
        xif.result_ready = 1'b0;
        check_eq({tag, "_ready_after"}, 32'(xif.issue_ready), 32'd1);
        check_eq({tag, "_valid_after"}, 32'(xif.result_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [3:0] id,
                          input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_data, input logic exp_we);
        logic rdy, acc, wb;
        int   lat;
        do_issue(mk_instr(f3, rd), id, a, b, 1'b1, 1'b0, rdy, acc, wb);
        check_eq({tag, "_ready"}, 32'(rdy), 32'd1);
        check_eq({tag, "_accept"}, 32'(acc), 32'd1);
        check_eq({tag, "_writeback"}, 32'(wb), 32'(exp_we));
        wait_result(lat);
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_data"}, xif.result.data, exp_data);
        check_eq({tag, "_rd"}, 32'(xif.result.rd), 32'(rd));
        check_eq({tag, "_id"}, 32'(xif.result.id), 32'(id));
        check_eq({tag, "_we"}, 32'(xif.result.we), 32'(exp_we));
        take_result(tag);
    endtask

    logic [31:0] bad_instr [3];

    initial begin
        logic rdy, acc, wb;
        int   lat;

        xif.compressed_valid = 1'b0;
        xif.compressed_req   = '0;
        xif.issue_valid      = 1'b0;
        xif.issue_req        = '0;
        xif.issue_req.rs_valid = 2'b11;
        xif.commit_valid     = 1'b0;
        xif.commit           = '0;
        xif.mem_ready        = 1'b0;
        xif.mem_resp         = '0;
        xif.mem_result_valid = 1'b0;
        xif.mem_result       = '0;
        xif.result_ready     = 1'b0;

        // Reset behaviour, with a valid MAC presented on issue_req.
        xif.issue_req.instr = mk_instr(3'b000, 5'd10);
        step();
        step();
        check_eq("rst_issue_ready", 32'(xif.issue_ready), 32'd0);
        check_eq("rst_accept", 32'(xif.issue_resp.accept), 32'd0);
        check_eq("rst_result_valid", 32'(xif.result_valid), 32'd0);
        check_eq("rst_result_data", xif.result.data, 32'd0);
        check_eq("rst_compressed_ready", 32'(xif.compressed_ready), 32'd0);
        check_eq("rst_mem_valid", 32'(xif.mem_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("idle_issue_ready", 32'(xif.issue_ready), 32'd1);
        xif.issue_req.rs_valid = 2'b01;
        #1;
        check_eq("rs_invalid_not_ready", 32'(xif.issue_ready), 32'd0);
        xif.issue_req.rs_valid = 2'b11;
        step();

        // MAC and modulo-2^32 wrap: 15 + 0xFFFFFFFE = 0x0000000D.
        run_op("mac1", 3'b000, 4'd2, 5'd10, 32'd3, 32'd5, 5, 32'd15, 1'b1);
        run_op("mac_wrap", 3'b000, 4'd3, 5'd11, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_000D, 1'b1);
        run_op("mac_bytes", 3'b000, 4'd1, 5'd1, 32'h0000_0010, 32'h0102_0304, 5,
               32'h1020_304D, 1'b1);
        run_op("rdacc", 3'b001, 4'd2, 5'd2, 32'd0, 32'd0, 2, 32'h1020_304D, 1'b1);
        run_op("clr_restore", 3'b010, 4'd3, 5'd3, 32'd0, 32'd0, 2, 32'd0, 1'b0);
        run_op("mac_restore", 3'b000, 4'd4, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF3, 5,
               32'h0000_000D, 1'b1);

        // Late commit with a foreign id in between: popcount(0xF0F00001) = 9.
        do_issue(mk_instr(3'b011, 5'd7), 4'd5, 32'hF0F0_0001, 32'd0, 1'b0, 1'b0, rdy, acc, wb);
        check_eq("late_accept", 32'(acc), 32'd1);
        check_eq("late_rv_t1", 32'(xif.result_valid), 32'd0);
        step();
        commit_pulse(4'd3, 1'b0);
        check_eq("late_rv_t3", 32'(xif.result_valid), 32'd0);
        check_eq("late_ready_t3", 32'(xif.issue_ready), 32'd0);
        step();
        commit_pulse(4'd5, 1'b0);
        check_eq("late_rv_t5", 32'(xif.result_valid), 32'd0);
        step();
        check_eq("late_rv_t6", 32'(xif.result_valid), 32'd1);
        check_eq("late_data", xif.result.data, 32'd9);
        check_eq("late_id", 32'(xif.result.id), 32'd5);
        take_result("late");

        // Kill after issue, then kill in the issue cycle; acc must be untouched.
        do_issue(mk_instr(3'b000, 5'd9), 4'd1, 32'd7, 32'd7, 1'b0, 1'b0, rdy, acc, wb);
        check_eq("kill_accept", 32'(acc), 32'd1);
        commit_pulse(4'd1, 1'b1);
        check_eq("kill_ready", 32'(xif.issue_ready), 32'd1);
        check_eq("kill_rv", 32'(xif.result_valid), 32'd0);
        do_issue(mk_instr(3'b000, 5'd9), 4'd4, 32'd7, 32'd7, 1'b1, 1'b1, rdy, acc, wb);
        check_eq("kill_now_ready", 32'(xif.issue_ready), 32'd1);
        step();
        step();
        check_eq("kill_now_rv", 32'(xif.result_valid), 32'd0);
        run_op("rdacc_after_kill", 3'b001, 4'd6, 5'd12, 32'd0, 32'd0, 2, 32'h0000_000D, 1'b1);

        // Non-accepted encodings: OP opcode, funct3=100, nonzero funct7.
        bad_instr[0] = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        bad_instr[1] = mk_instr(3'b100, 5'd3);
        bad_instr[2] = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, OPCODE_CUSTOM0};
        for (int i = 0; i < 3; i++) begin
            do_issue(bad_instr[i], 4'd7, 32'd1, 32'd1, 1'b0, 1'b0, rdy, acc, wb);
            check_eq($sformatf("bad%0d_ready", i), 32'(rdy), 32'd1);
            check_eq($sformatf("bad%0d_accept", i), 32'(acc), 32'd0);
            check_eq($sformatf("bad%0d_writeback", i), 32'(wb), 32'd0);
            check_eq($sformatf("bad%0d_idle", i), 32'(xif.issue_ready), 32'd1);
            step();
            check_eq($sformatf("bad%0d_rv", i), 32'(xif.result_valid), 32'd0);
        end

        // Result back-pressure for 6 cycles.
        do_issue(mk_instr(3'b001, 5'd13), 4'd8, 32'd0, 32'd0, 1'b1, 1'b0, rdy, acc, wb);
        wait_result(lat);
        check_eq("bp_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 6; i++) begin
            check_eq("bp_valid", 32'(xif.result_valid), 32'd1);
            check_eq("bp_data", xif.result.data, 32'h0000_000D);
            check_eq("bp_rd", 32'(xif.result.rd), 32'd13);
            check_eq("bp_ready_low", 32'(xif.issue_ready), 32'd0);
            step();
        end
        take_result("bp");

        run_op("clracc", 3'b010, 4'd9, 5'd14, 32'd0, 32'd0, 2, 32'd0, 1'b0);
        run_op("rdacc_zero", 3'b001, 4'd10, 5'd15, 32'd0, 32'd0, 2, 32'd0, 1'b1);
        run_op("popcnt_all", 3'b011, 4'd11, 5'd6, 32'hFFFF_FFFF, 32'd0, 2, 32'd32, 1'b1);
        run_op("mac_pre_rst", 3'b000, 4'd12, 5'd5, 32'd3, 32'd5, 5, 32'd15, 1'b1);

        // Reset during the second MAC EXEC cycle.
        do_issue(mk_instr(3'b000, 5'd8), 4'd13, 32'h100, 32'h100, 1'b1, 1'b0, rdy, acc, wb);
        step();
        rst_n = 1'b0;
        step();
        check_eq("midrst_rv", 32'(xif.result_valid), 32'd0);
        check_eq("midrst_ready", 32'(xif.issue_ready), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("postrst_ready", 32'(xif.issue_ready), 32'd1);
        run_op("rdacc_after_rst", 3'b001, 4'd14, 5'd16, 32'd0, 32'd0, 2, 32'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xif_mac_coproc.md
# xif_mac_coproc

Single-issue CORE-V-XIF 1.0 coprocessor (responder side) that accepts custom-0 instructions from the CV32E20 XIF bridge and executes them. It holds a 32-bit accumulator and supports multiply-accumulate, accumulator read, accumulator clear and popcount. It connects to the coprocessor modports of `if_xif`, facing the CPU-side bridge inside `core_v_mini_mcu`. It handles issue, commit and result handshakes and keeps one instruction in flight.

## Interface
- `X_ID_WIDTH`, 4: width of the instruction `id` field; must match `if_xif`.
- `X_NUM_RS`, 2: number of source-register ports in `if_xif` (2 or 3); only `rs[1:0]` are used.
- `X_RFR_WIDTH`, 32: register read width; only 32 is supported.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `xif_compressed_if`  modport  `if_xif.coproc_compressed`  drives `compressed_ready=0` and `compressed_resp='0`.
- `xif_issue_if`  modport  `if_xif.coproc_issue`  uses `issue_valid`, `issue_ready`, `issue_req.{instr,id,rs,rs_valid}` and `issue_resp`.
- `xif_commit_if`  modport  `if_xif.coproc_commit`  uses `commit_valid`, `commit.{id,commit_kill}`.
- `xif_mem_if`  modport  `if_xif.coproc_mem`  drives `mem_valid=0` and `mem_req='0`.
- `xif_mem_result_if`  modport  `if_xif.coproc_mem_result`  is unused (input only).
- `xif_result_if`  modport  `if_xif.coproc_result`  uses `result_valid`, `result_ready`, `result.{id,data,rd,we}`; all other result fields are driven to 0.

## Operation
- **Decode.** Accepted means `instr[6:0]=7'b0001011`, `instr[31:25]=0` and `instr[14:12]` is one of the following:
  - `000` MAC: `acc += rs1*rs2` (low 32 bits); returns the new `acc`.
  - `001` RDACC: returns `acc`.
  - `010` CLRACC: sets `acc = 0`; no writeback.
  - `011` POPCNT: returns popcount of `rs1`.
- **Issue response.** `issue_resp.accept` is 1 for accepted instructions. `writeback` = accept && funct3≠`010`. All other `issue_resp` fields are 0.
- **Issue ready.** `issue_ready = (state==IDLE) && rs_valid[1:0]==2'b11`.
  - A non-accepted instruction completes the handshake with `accept=0` and causes no state change.
- **Latched on an accepted handshake:** `id`, `rd=instr[11:7]`, funct3, `rs1`, `rs2`, `we`.
- **FSM states:** IDLE, WAIT_COMMIT, EXEC, RESULT.
  - IDLE → EXEC on an accepted handshake with a matching non-kill commit in the same cycle.
  - IDLE → WAIT_COMMIT on an accepted handshake otherwise.
  - IDLE → IDLE if the handshake includes a matching kill commit.
  - WAIT_COMMIT → EXEC on `commit_valid && commit.id==id && !commit_kill`.
  - WAIT_COMMIT → IDLE on a matching commit with kill. Nothing executes, `acc` is untouched and no result is produced.
  - Commits with a non-matching id are ignored in every state.
  - EXEC → RESULT when the operation completes: 1 cycle for RDACC/CLRACC/POPCNT, 4 cycles for MAC.
  - RESULT → IDLE on `result_valid && result_ready`.
- **Accumulator update.** `acc` updates only on the last EXEC cycle, so it changes only for committed instructions. Wrap-around is modulo 2^32.
- **Result hold.** `result_valid` stays asserted with stable `id/data/rd/we` until `result_ready`. CLRACC returns `data=0`, `we=0`.
- **Reset.** Reset at any point, including mid-EXEC or mid-RESULT, forces IDLE, `acc=0` and all latches to 0.

## Timing
- **Output values under reset:** `issue_ready=0`, `issue_resp='0`, `result_valid=0`, `result='0`, `compressed_ready=0`, `mem_valid=0`.
- **Issue response is combinational.** `issue_resp` depends on `issue_req` in the same cycle.
- **Latency.** Issue and commit handshake in cycle T gives the first `result_valid` at:
  - T+2 for single-cycle ops.
  - T+5 for MAC.
  - A late commit at cycle C gives C+2 or C+5.
- **MAC multiplier.** Iterative, 8 bits of `rs2` per cycle (32x8 partial product per cycle, 4 cycles, LSB byte first), low 32 bits kept.
- **Back-to-back.** `issue_ready` returns high in the cycle after the result handshake. There is no overlap between instructions.

## Structure
- **Package `xif_mac_pkg`:**
  - `OPCODE_CUSTOM0` constant.
  - `funct3` enum `xmac_op_e` {MAC, RDACC, CLRACC, POPCNT}.
  - FSM enum `xmac_state_e`.
  - `MAC_CYCLES=4`.
- **Sub-module `xif_mac_mul_iter`:**
  - Ports: start, `a[31:0]`, `b[31:0]`, busy, done pulse, `p[31:0]`.
  - Contains the 2-bit byte counter and partial-sum register.
- **Top level:** FSM, decode, id/rd latches, accumulator, popcount and XIF tie-offs.

## Test plan
- **MAC.** `acc=0`; issue MAC `rs1=3`, `rs2=5`, id 2, rd x10, commit with issue → `accept=1`, `writeback=1`; `result_valid` at T+5 with `data=15`, `rd=10`, `id=2`, `we=1`. Then MAC `rs1=0xFFFFFFFF`, `rs2=2` → `data=0x0000000D` (wrap).
- **Late commit and id filtering.** Issue POPCNT `rs1=0xF0F00001`, id 5; send commit id 3 at T+2 (ignored), then commit id 5 at T+4 → `result_valid` at T+6 with `data=9`.
- **Kill.** Issue MAC `rs1=7`, `rs2=7`, then commit with kill → no `result_valid`, `issue_ready` high at the next cycle; a following RDACC returns the prior `acc` unchanged.
- **Non-accepted instruction.** Issue `instr` with opcode 0110011 or funct3=`100` → handshake completes with `accept=0`, `writeback=0`; FSM stays in IDLE.
- **Result back-pressure.** RDACC with `result_ready` held 0 for 6 cycles → `result_valid` and data stable, `issue_ready=0` throughout. CLRACC → `we=0`, `data=0`; a subsequent RDACC returns 0.
- **Reset mid-operation.** Assert `rst_ni=0` during MAC EXEC cycle 2 → next cycle `result_valid=0`, `issue_ready=0`; after release, RDACC returns 0.
